inv_key_sched: RTL
==================

Name: inv_key_sched

Overview:
- Sequential AES-128 round-key generator for the decrypt path.
- Takes the 128-bit cipher key and expands it forward to the round-10 key, one round per clock.
- Then walks the schedule backwards, streaming round keys 10, 9, ..., 0 over a valid/ready handshake. Consumers therefore receive keys in decryption order without storing all 11 keys.
- Sits between the key register and the inverse-cipher round datapath.

Parameters:
- NROUNDS, 10, number of expansion rounds (fixed at 10 for AES-128; any other value is unsupported).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key; word w0 = [127:96], w3 = [31:0].
- key_load  input  1  single-cycle request to start a schedule; sampled only in IDLE.
- busy  output  1  high from the cycle after key_load is accepted until the final handshake.
- key_out  output  128  current round key, same word order as key_in.
- key_idx  output  4  round number of key_out (10 down to 0).
- key_valid  output  1  key_out/key_idx are valid.
- key_ready  input  1  consumer accepts key_out when key_valid && key_ready.
- key_last  output  1  key_valid && key_idx==0.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; key_out=0, key_idx=0, key_valid=0, key_last=0, busy=0; work register and round counter cleared. Reset overrides every other input, including mid-EXPAND and mid-OUT.
- Rcon table, indexed 0..9: 01,02,04,08,10,20,40,80,1b,36, placed in byte [31:24] of the word.
- Forward step with rcon r, input words k0..k3:
  - t = SubWord(RotWord(k3)) ^ r
  - n0 = k0^t, n1 = k1^n0, n2 = k2^n1, n3 = k3^n2.
- Inverse step from round i to round i-1, with r = rcon[i-1]:
  - p3 = k3^k2, p2 = k2^k1, p1 = k1^k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ r.
- A single 4-byte forward S-box block is shared: in EXPAND it takes RotWord(k3); in OUT it takes RotWord(p3). No inverse S-box is required.
- State IDLE:
  - key_load=1 at edge E0 → work=key_in, cnt=0, state=EXPAND, busy=1.
  - key_load=0 → remain in IDLE.
- State EXPAND:
  - Each edge: work=fwd_step(work, rcon[cnt]), cnt++.
  - At the edge performing step cnt==9 (edge E10): key_out = new work, key_idx=10, key_valid=1, state=OUT.
  - Latency: key_valid is first visible 10 clocks after the key_load edge.
- State OUT:
  - key_valid high; key_out and key_idx held stable while key_ready=0.
  - On an edge with key_valid && key_ready and key_idx>0: key_out = inv_step(key_out, rcon[key_idx-1]), key_idx--, key_valid stays 1.
  - With key_ready held high, throughput is one key per cycle; 11 keys take 11 cycles.
  - On an edge with key_valid && key_ready and key_idx==0: state=IDLE, key_valid=0, busy=0. key_out keeps its last value; key_idx stays 0.
- key_load while busy=1 is ignored, with no effect on the sequence. key_load arriving on the same edge that returns to IDLE is also ignored; it must be re-presented in IDLE.
- key_in is sampled only at the accepting edge. Later changes to key_in have no effect.
- key_out must never change while key_valid=1 and key_ready=0.

Optional Feature:
- Macro INV_KEY_DIRECT_LOAD_EN.
- Defined:
  - Adds input port key_is_last (1 bit).
  - key_load with key_is_last=1 loads key_in as the round-10 key and goes directly to OUT: key_valid=1, key_idx=10, visible one edge after load.
  - key_load with key_is_last=0 behaves as the base design.
- Undefined: the port is absent; every key_load runs EXPAND.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1 → key_valid 10 clocks after load with key_idx=10, key_out=d014f9a8c9ee2589e13f0cc8b6630ca6; the next 10 cycles step down; key_idx=1 gives a0fafe1788542cb123a339392a6c7605; key_idx=0 gives 2b7e...4f3c with key_last=1; busy=0 on the following cycle.
- All-zero key → key_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e; key_idx=1 gives 62636363626363636263636362636363; key_idx=0 gives zero.
- Backpressure: FIPS key, drop key_ready for 5 cycles while key_idx=7 → key_out and key_idx unchanged for those cycles, no key skipped; the full sequence matches the first scenario.
- key_load pulsed with key_in=0 during EXPAND and again during OUT → ignored; the FIPS sequence is unchanged.
- rst asserted at EXPAND cnt=4, and again at OUT key_idx=5 → next cycle all outputs 0, state IDLE; a fresh FIPS load reproduces the first scenario exactly.
- INV_KEY_DIRECT_LOAD_EN: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_is_last=1 → key_valid one cycle later with key_idx=10; sequence ends at key_idx=0 with 2b7e151628aed2a6abf7158809cf4f3c.

Source files
------------

// File: rtl/inv_key_sched_if.sv
// Key-load request and decrypt-order round-key stream for inv_key_sched.
// Macro INV_KEY_DIRECT_LOAD_EN adds key_is_last (key_in is already the round-10 key).
interface inv_key_sched_if;
   logic [127:0] key_in;
   logic         key_load;
`ifdef INV_KEY_DIRECT_LOAD_EN
   logic         key_is_last;
`endif
   logic         busy;
   logic [127:0] key_out;
   logic [3:0]   key_idx;
   logic         key_valid;
   logic         key_ready;
   logic         key_last;

   modport master (
      output key_in,
      output key_load,
`ifdef INV_KEY_DIRECT_LOAD_EN
      output key_is_last,
`endif
      output key_ready,
      input  busy,
      input  key_out,
      input  key_idx,
      input  key_valid,
      input  key_last
   );

   modport slave (
      input  key_in,
      input  key_load,
`ifdef INV_KEY_DIRECT_LOAD_EN
      input  key_is_last,
`endif
      input  key_ready,
      output busy,
      output key_out,
      output key_idx,
      output key_valid,
      output key_last
   );
endinterface

// File: rtl/inv_key_sched.sv
// AES-128 round-key generator for decryption: expands forward to round 10, then streams 10..0.
// Macro INV_KEY_DIRECT_LOAD_EN: key_load with key_is_last=1 takes key_in as the round-10 key.
module inv_key_sched #(
   parameter int unsigned NROUNDS = 10
) (
   input logic            clk,
   input logic            rst,
   inv_key_sched_if.slave kif
);

   localparam logic [3:0] LAST_IDX = 4'(NROUNDS);

   localparam logic [127:0] SBOX_ROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [127:0] row;
      logic [3:0]   col;
      row = SBOX_ROW[b[7:4]];
      col = 4'd15 - b[3:0];
      return row[{col, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd0:    return 8'h01;
         4'd1:    return 8'h02;
         4'd2:    return 8'h04;
         4'd3:    return 8'h08;
         4'd4:    return 8'h10;
         4'd5:    return 8'h20;
         4'd6:    return 8'h40;
         4'd7:    return 8'h80;
         4'd8:    return 8'h1b;
         4'd9:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, EXPAND, OUT} state_e;

   state_e       state_q;
   logic [127:0] work_q;
   logic [127:0] key_q;
   logic [3:0]   cnt_q;
   logic [3:0]   idx_q;
   logic         valid_q;
   logic         last_q;
   logic         busy_q;

   logic [31:0]  k0, k1, k2, k3;
   logic [31:0]  q0, q1, q2, q3;
   logic [31:0]  p0, p1, p2, p3;
   logic [31:0]  n0, n1, n2, n3;
   logic [31:0]  sb_in, sb_t;
   logic [3:0]   rc_idx;
   logic [127:0] fwd_d, inv_d;
   logic         direct_load;

   assign {k0, k1, k2, k3} = work_q;
   assign {q0, q1, q2, q3} = key_q;

`ifdef INV_KEY_DIRECT_LOAD_EN
   assign direct_load = kif.key_is_last;
`else
   assign direct_load = 1'b0;
`endif

   // One S-box word serves both directions: RotWord(k3) while expanding, RotWord(p3) while streaming.
   always_comb begin
      p3     = q3 ^ q2;
      p2     = q2 ^ q1;
      p1     = q1 ^ q0;
      sb_in  = (state_q == OUT) ? p3 : k3;
      rc_idx = (state_q == OUT) ? (idx_q - 4'd1) : cnt_q;
      sb_t   = sub_rot_word(sb_in) ^ {rcon(rc_idx), 24'h000000};
      n0     = k0 ^ sb_t;
      n1     = k1 ^ n0;
      n2     = k2 ^ n1;
      n3     = k3 ^ n2;
      p0     = q0 ^ sb_t;
      fwd_d  = {n0, n1, n2, n3};
      inv_d  = {p0, p1, p2, p3};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         key_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (kif.key_load) begin
                  busy_q <= 1'b1;
                  if (direct_load) begin
                     key_q   <= kif.key_in;
                     idx_q   <= LAST_IDX;
                     valid_q <= 1'b1;
                     last_q  <= 1'b0;
                     state_q <= OUT;
                  end else begin
                     work_q  <= kif.key_in;
                     cnt_q   <= '0;
                     state_q <= EXPAND;
                  end
               end
            end
            EXPAND: begin
               work_q <= fwd_d;
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == LAST_IDX - 4'd1) begin
                  key_q   <= fwd_d;
                  idx_q   <= LAST_IDX;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  state_q <= OUT;
               end
            end
            OUT: begin
               if (kif.key_ready) begin
                  if (idx_q != 4'd0) begin
                     key_q  <= inv_d;
                     idx_q  <= idx_q - 4'd1;
                     last_q <= (idx_q == 4'd1);
                  end else begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign kif.busy      = busy_q;
   assign kif.key_out   = key_q;
   assign kif.key_idx   = idx_q;
   assign kif.key_valid = valid_q;
   assign kif.key_last  = last_q;

endmodule
